// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Issues one latched operation at a time and holds the captured result until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a request; grants one requester combinationally
// EXEC  | issue registers drive the ALU; result captured at the end of this cycle
// HOLD  | result presented on res_*; waits for res_ready_i
module alu_arbiter (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       req0_valid_i,
    input  logic [2:0] req0_op_i,
    input  logic [7:0] req0_a_i,
    input  logic [7:0] req0_b_i,
    output logic       req0_ready_o,
    input  logic       req1_valid_i,
    input  logic [2:0] req1_op_i,
    input  logic [7:0] req1_a_i,
    input  logic [7:0] req1_b_i,
    output logic       req1_ready_o,
    output logic [2:0] alu_op_o,
    output logic [7:0] alu_a_o,
    output logic [7:0] alu_b_o,
    input  logic [7:0] alu_out_i,
    input  logic       alu_zero_i,
    output logic       res_valid_o,
    output logic [7:0] res_data_o,
    output logic       res_zero_o,
    output logic       res_tag_o,
    input  logic       res_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       last_grant_q;
    logic [2:0] op_q;
    logic [7:0] a_q, b_q;
    logic       res_valid_q;
    logic [7:0] res_data_q;
    logic       res_zero_q;
    logic       res_tag_q;
    logic       grant;
    logic       accept;

    // Round-robin only matters under contention; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant = ~last_grant_q;
        end else if (req1_valid_i) begin
            grant = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = HOLD;
            HOLD:    if (res_valid_q && res_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is gated by reset so no handshake can complete on a reset edge.
    always_comb begin
        accept       = 1'b0;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        if (state_q == IDLE && !reset_i && (req0_valid_i || req1_valid_i)) begin
            accept       = 1'b1;
            req0_ready_o = ~grant;
            req1_ready_o = grant;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_grant_q <= 1'b1;
            op_q         <= 3'd0;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            res_valid_q  <= 1'b0;
            res_data_q   <= 8'd0;
            res_zero_q   <= 1'b0;
            res_tag_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q         <= grant ? req1_op_i : req0_op_i;
                a_q          <= grant ? req1_a_i  : req0_a_i;
                b_q          <= grant ? req1_b_i  : req0_b_i;
                res_tag_q    <= grant;
                last_grant_q <= grant;
            end
            if (state_q == EXEC) begin
                res_data_q  <= alu_out_i;
                res_zero_q  <= alu_zero_i;
                res_valid_q <= 1'b1;
            end else if (state_q == HOLD && res_valid_q && res_ready_i) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign alu_op_o    = op_q;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_zero_o  = res_zero_q;
    assign res_tag_o   = res_tag_q;

endmodule
